// File: rtl/unidade_controle_multiciclo.sv
// ---------------------------------------------------------------------------
// unidade_controle_multiciclo
//
// Multicycle control FSM for the nRISC core. Walks each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB). It drives every datapath enable,
// owns the COND capture/clear protocol and bounds memory wait states with a
// timeout that halts the core and raises a sticky fault flag.
//
// Parameters
//   WAIT_MAX    consecutive mem_ready=0 cycles in one access that count as a
//               fault (1..255)
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset, returns to FETCH
//   opcode      instr[7:4] from the IR, meaningful from DECODE onward
//   cond_atual  current COND register value
//   mem_ready   memory completes the pending access this cycle
//   pc_write    PC load enable          pc_src   00 PC+1, 01 branch, 10 jump
//   ir_write    IR load enable          iord     0 PC, 1 ALU result address
//   mem_read    memory read request     mem_write memory write request
//   reg_write   register file write     wb_sel   00 ALU, 01 mem, 10 imm
//   alu_op      000 ADD 001 SUB 010 AND 011 OR 100 SLT
//   cond_write  COND mux takes the ALU flag this cycle
//   reset_cond  synchronous clear of COND
//   halted      core stopped            erro     sticky memory timeout fault
// ---------------------------------------------------------------------------
module unidade_controle_multiciclo #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       cond_atual,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [2:0] alu_op,
    output logic       cond_write,
    output logic       reset_cond,
    output logic       halted,
    output logic       erro
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_SLT = 4'h4;
    localparam logic [3:0] OP_CEQ = 4'h5;
    localparam logic [3:0] OP_LW  = 4'h6;
    localparam logic [3:0] OP_SW  = 4'h7;
    localparam logic [3:0] OP_BRC = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_LI  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [8:0] WAIT_LIMIT = 9'(WAIT_MAX);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       erro_q, erro_d;
    logic [8:0] wait_inc;
    logic       timeout;

    // One extra bit so the comparison never wraps when WAIT_MAX is 255.
    assign wait_inc = {1'b0, wait_q} + 9'd1;
    assign timeout  = (wait_inc == WAIT_LIMIT);
    assign erro     = erro_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            erro_q  <= erro_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = 8'd0;      // any cycle that is not a wait cycle clears it
        erro_d     = erro_q;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        alu_op     = 3'b000;
        cond_write = 1'b0;
        reset_cond = 1'b0;
        halted     = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    erro_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_inc[7:0];
                end
            end

            S_DECODE: begin
                state_d = (opcode == OP_HLT) ? S_HALT : S_EXEC;
            end

            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    // The four plain ALU opcodes share their low bits with alu_op.
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        alu_op  = opcode[2:0];
                        state_d = S_WB;
                    end
                    OP_LI: begin
                        state_d = S_WB;
                    end
                    OP_SLT: begin
                        alu_op     = 3'b100;
                        cond_write = 1'b1;
                    end
                    OP_CEQ: begin
                        alu_op     = 3'b001;
                        cond_write = 1'b1;
                    end
                    OP_LW, OP_SW: begin
                        state_d = S_MEM;
                    end
                    OP_BRC: begin
                        // COND is consumed by every BRC, taken or not.
                        reset_cond = 1'b1;
                        if (cond_atual) begin
                            pc_write = 1'b1;
                            pc_src   = 2'b01;
                        end
                    end
                    OP_JMP: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                iord      = 1'b1;
                mem_read  = (opcode == OP_LW);
                mem_write = (opcode == OP_SW);
                if (opcode != OP_LW && opcode != OP_SW) begin
                    state_d = S_FETCH;
                end else if (mem_ready) begin
                    state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    erro_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_inc[7:0];
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                if (opcode == OP_LW) begin
                    wb_sel = 2'b01;
                end else if (opcode == OP_LI) begin
                    wb_sel = 2'b10;
                end
                state_d = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // The state is already FETCH while reset is high; keep a mem_ready
        // arriving during reset from loading IR or PC.
        if (reset) begin
            ir_write = 1'b0;
            pc_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
module tb_unidade_controle_multiciclo;

    localparam int unsigned WMAX = 4;

    localparam logic [3:0] ADD = 4'h0;
    localparam logic [3:0] SUB = 4'h1;
    localparam logic [3:0] AND = 4'h2;
    localparam logic [3:0] OR  = 4'h3;
    localparam logic [3:0] SLT = 4'h4;
    localparam logic [3:0] CEQ = 4'h5;
    localparam logic [3:0] LW  = 4'h6;
    localparam logic [3:0] SW  = 4'h7;
    localparam logic [3:0] BRC = 4'h8;
    localparam logic [3:0] JMP = 4'h9;
    localparam logic [3:0] LI  = 4'hA;
    localparam logic [3:0] HLT = 4'hF;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       cond_atual = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [2:0] alu_op;
    logic       cond_write;
    logic       reset_cond;
    logic       halted;
    logic       erro;

    unidade_controle_multiciclo #(.WAIT_MAX(WMAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .cond_atual (cond_atual),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .wb_sel     (wb_sel),
        .alu_op     (alu_op),
        .cond_write (cond_write),
        .reset_cond (reset_cond),
        .halted     (halted),
        .erro       (erro)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [2:0] alu_op;
        logic       cond_write;
        logic       reset_cond;
        logic       halted;
        logic       erro;
    } outs_t;

    typedef struct {
        logic       ready;
        logic [3:0] op;
        outs_t      exp;
    } step_t;

    step_t trace_q[$];
    int checks = 0;
    int failures = 0;

    function automatic outs_t get_obs();
        outs_t o;
        o.pc_write   = pc_write;
        o.pc_src     = pc_src;
        o.ir_write   = ir_write;
        o.iord       = iord;
        o.mem_read   = mem_read;
        o.mem_write  = mem_write;
        o.reg_write  = reg_write;
        o.wb_sel     = wb_sel;
        o.alu_op     = alu_op;
        o.cond_write = cond_write;
        o.reset_cond = reset_cond;
        o.halted     = halted;
        o.erro       = erro;
        return o;
    endfunction

    // ALU operation an instruction asks for in its execute cycle.
    function automatic logic [2:0] alu_of(input logic [3:0] op);
        case (op)
            SUB, CEQ: return 3'b001;
            AND:      return 3'b010;
            OR:       return 3'b011;
            SLT:      return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

    // Reference model: the cycle-by-cycle output trace of one instruction,
    // with nf fetch wait cycles and nm memory wait cycles.
    task automatic build_trace(input logic [3:0] op, input logic cond,
                               input int nf, input int nm);
        step_t s;
        outs_t e;
        logic  mem_op;
        logic  has_wb;
        trace_q.delete();
        mem_op = (op == LW) || (op == SW);
        has_wb = (op == ADD) || (op == SUB) || (op == AND) || (op == OR) ||
                 (op == LI) || (op == LW);
        for (int i = 0; i <= nf; i++) begin
            e = '0;
            e.mem_read = 1'b1;
            if (i == nf) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
            end
            s.ready = (i == nf);
            s.op    = 4'($urandom);   // IR not yet valid during fetch
            s.exp   = e;
            trace_q.push_back(s);
        end
        e = '0;
        s.ready = 1'($urandom);
        s.op    = op;
        s.exp   = e;
        trace_q.push_back(s);
        if (op == HLT) return;
        e = '0;
        e.alu_op     = alu_of(op);
        e.cond_write = (op == SLT) || (op == CEQ);
        e.reset_cond = (op == BRC);
        if (op == JMP) begin
            e.pc_write = 1'b1;
            e.pc_src   = 2'b10;
        end else if (op == BRC && cond) begin
            e.pc_write = 1'b1;
            e.pc_src   = 2'b01;
        end
        s.ready = 1'($urandom);
        s.exp   = e;
        trace_q.push_back(s);
        if (mem_op) begin
            for (int j = 0; j <= nm; j++) begin
                e = '0;
                e.iord      = 1'b1;
                e.mem_read  = (op == LW);
                e.mem_write = (op == SW);
                s.ready = (j == nm);
                s.exp   = e;
                trace_q.push_back(s);
            end
        end
        if (has_wb) begin
            e = '0;
            e.reg_write = 1'b1;
            e.wb_sel    = (op == LW) ? 2'b01 : (op == LI) ? 2'b10 : 2'b00;
            s.ready = 1'($urandom);
            s.exp   = e;
            trace_q.push_back(s);
        end
    endtask

    // Plays the built trace (or its first 'limit' cycles). Entered and left
    // 1 time unit after a rising edge.
    task automatic run_trace(input string name, input int limit);
        int n;
        outs_t got;
        n = (limit < 0 || limit > trace_q.size()) ? trace_q.size() : limit;
        for (int k = 0; k < n; k++) begin
            opcode    = trace_q[k].op;
            mem_ready = trace_q[k].ready;
            #2;
            got = get_obs();
            checks++;
            if (got !== trace_q[k].exp) begin
                failures++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, trace_q[k].exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_halted(input string name, input int n, input logic erro_exp);
        outs_t e;
        outs_t got;
        e = '0;
        e.halted = 1'b1;
        e.erro   = erro_exp;
        for (int k = 0; k < n; k++) begin
            opcode     = 4'($urandom);
            mem_ready  = 1'($urandom);
            cond_atual = 1'($urandom);
            #2;
            got = get_obs();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        outs_t e;
        outs_t got;
        e = '0;
        e.mem_read = 1'b1;
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 4'($urandom);
        #1;
        got = get_obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_hold: got %h expected %h", got, e);
        end
        mem_ready = 1'b1;
        #1;
        got = get_obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_ready: got %h expected %h", got, e);
        end
        @(posedge clk);
        #1;
        got = get_obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_edge: got %h expected %h", got, e);
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        outs_t e;
        outs_t got;
        do_reset();
        e = '0;
        e.mem_read = 1'b1;
        #1;
        got = get_obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_release: got %h expected %h", got, e);
        end
        #1;
        $display("test_reset done");
        build_trace(ADD, 1'b0, 0, 0);
        run_trace("after_reset_add", -1);
    endtask

    task automatic test_alu_sequence();
        cond_atual = 1'b0;
        build_trace(ADD, 1'b0, 0, 0);
        for (int k = 0; k < trace_q.size(); k++) trace_q[k].ready = 1'b1;
        run_trace("alu_add", -1);
        build_trace(OR, 1'b0, 0, 0);
        run_trace("alu_or", -1);
        build_trace(LI, 1'b0, 0, 0);
        run_trace("li", -1);
        $display("test_alu_sequence done");
    endtask

    task automatic test_branch();
        cond_atual = 1'b1;
        build_trace(CEQ, 1'b1, 0, 0);
        run_trace("ceq_1", -1);
        build_trace(BRC, 1'b1, 0, 0);
        run_trace("brc_taken", -1);
        cond_atual = 1'b0;
        build_trace(CEQ, 1'b0, 0, 0);
        run_trace("ceq_0", -1);
        build_trace(BRC, 1'b0, 0, 0);
        run_trace("brc_not_taken", -1);
        build_trace(JMP, 1'b0, 0, 0);
        run_trace("jmp", -1);
        $display("test_branch done");
    endtask

    task automatic test_lw_waits();
        int len;
        cond_atual = 1'b0;
        build_trace(LW, 1'b0, 0, 3);
        len = trace_q.size();
        checks++;
        if (len != 8) begin
            failures++;
            $display("FAIL lw_trace_len: got %0d expected 8", len);
        end
        run_trace("lw_wait3", -1);
        build_trace(SW, 1'b0, 2, 1);
        run_trace("sw_waits", -1);
        $display("test_lw_waits done");
    endtask

    task automatic test_timeout();
        outs_t e;
        outs_t got;
        do_reset();
        e = '0;
        e.mem_read = 1'b1;
        for (int k = 0; k < int'(WMAX); k++) begin
            opcode    = 4'($urandom);
            mem_ready = 1'b0;
            #2;
            got = get_obs();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL fetch_wait cycle %0d: got %h expected %h", k, got, e);
            end
            @(posedge clk);
            #1;
        end
        check_halted("fetch_timeout_halt", 6, 1'b1);
        do_reset();
        // Ready on the last permitted wait cycle: no fault, in fetch and in MEM.
        build_trace(ADD, 1'b0, int'(WMAX) - 1, 0);
        run_trace("fetch_edge_ok", -1);
        build_trace(LW, 1'b0, 0, int'(WMAX) - 1);
        run_trace("mem_edge_ok", -1);
        // Timeout inside MEM.
        build_trace(LW, 1'b0, 0, 10);
        run_trace("mem_timeout_pre", 3 + int'(WMAX));
        check_halted("mem_timeout_halt", 4, 1'b1);
        do_reset();
        $display("test_timeout done");
    endtask

    task automatic test_hlt();
        build_trace(HLT, 1'b0, 1, 0);
        run_trace("hlt", -1);
        check_halted("hlt_hold", 20, 1'b0);
        do_reset();
        $display("test_hlt done");
    endtask

    task automatic test_reset_mid_access();
        outs_t e;
        outs_t got;
        cond_atual = 1'b0;
        build_trace(SW, 1'b0, 0, 3);
        run_trace("sw_pre", 4);
        mem_ready = 1'b0;
        #2;
        e = '0;
        e.iord      = 1'b1;
        e.mem_write = 1'b1;
        got = get_obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL sw_mem_pending: got %h expected %h", got, e);
        end
        reset = 1'b1;
        #1;
        e = '0;
        e.mem_read = 1'b1;
        got = get_obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL sw_reset_drop: got %h expected %h", got, e);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        build_trace(ADD, 1'b0, 0, 0);
        run_trace("after_mid_reset", -1);
        $display("test_reset_mid_access done");
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        logic       c;
        int         nf;
        int         nm;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 14));
            c  = 1'($urandom);
            nf = int'($urandom_range(0, WMAX - 1));
            nm = int'($urandom_range(0, WMAX - 1));
            cond_atual = c;
            build_trace(op, c, nf, nm);
            $display("instr %0d op=%h cond=%0d nf=%0d nm=%0d cycles=%0d", i, op, c, nf, nm, trace_q.size());
            run_trace("random_instr", -1);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_alu_sequence();
        test_branch();
        test_lw_waits();
        test_timeout();
        test_hlt();
        test_reset_mid_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
